// File: rtl/ps2_rx_apb.sv
// PS/2 receive-only keyboard/mouse port behind an APB slave: it synchronises the lines, deframes
// 11-bit frames, queues the bytes in a FIFO and reports errors through sticky W1C flags and an irq.
module ps2_rx_apb #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- line synchronisers ----------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    logic w_fall;
    logic w_bit;
    assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
    // data taken from the stage aligned with the newer clock sample
    assign w_bit  = r_dat_sync[SYNC_STAGES-2];

    // ---------------- APB decode ----------------
    logic       w_access;
    logic       w_rd;
    logic       w_wr;
    logic [1:0] w_addr;

    assign w_access = psel & penable;
    assign w_rd     = w_access & ~pwrite;
    assign w_wr     = w_access & pwrite;
    assign w_addr   = paddr[3:2];
    assign pready   = 1'b1;

    // ---------------- control / status registers ----------------
    logic          r_enable;
    logic          r_irq_en;
    logic          r_ovf;
    logic          r_perr;
    logic          r_ferr;
    logic          r_irq;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_mem [FIFO_DEPTH];

    // ---------------- frame receiver ----------------
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_idle;
    logic [7:0]    r_shift;
    logic          r_start;
    logic          r_par;
    logic          r_push_valid;
    logic [7:0]    r_push_byte;
    logic          r_perr_ev;
    logic          r_ferr_ev;

    logic w_par_ok;
    logic w_frm_ok;
    assign w_par_ok = ^{r_shift, r_par};
    assign w_frm_ok = ~r_start & w_bit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bitcnt     <= '0;
            r_idle       <= '0;
            r_shift      <= '0;
            r_start      <= 1'b0;
            r_par        <= 1'b0;
            r_push_valid <= 1'b0;
            r_push_byte  <= '0;
            r_perr_ev    <= 1'b0;
            r_ferr_ev    <= 1'b0;
        end else begin
            r_push_valid <= 1'b0;
            r_perr_ev    <= 1'b0;
            r_ferr_ev    <= 1'b0;
            if (!r_enable) begin
                r_bitcnt <= '0;
                r_idle   <= '0;
            end else if (w_fall) begin
                r_idle <= '0;
                case (r_bitcnt)
                    4'd0:    r_start <= w_bit;
                    4'd9:    r_par   <= w_bit;
                    4'd10: begin
                        r_push_valid <= w_par_ok & w_frm_ok;
                        r_push_byte  <= r_shift;
                        r_perr_ev    <= ~w_par_ok;
                        r_ferr_ev    <= ~w_frm_ok;
                    end
                    default: r_shift <= {w_bit, r_shift[7:1]};
                endcase
                r_bitcnt <= (r_bitcnt == 4'd10) ? 4'd0 : r_bitcnt + 4'd1;
            end else if (r_bitcnt != 4'd0) begin
                if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_bitcnt  <= '0;
                    r_idle    <= '0;
                    r_ferr_ev <= 1'b1;
                end else begin
                    r_idle <= r_idle + TW'(1);
                end
            end
        end
    end

    // ---------------- FIFO and registers ----------------
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push_ok;
    logic       w_ovf_ev;
    logic [2:0] w_clr;
    logic [7:0] w_head;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = w_rd & (w_addr == 2'd0) & ~w_empty;
    // a pop in the same cycle frees the slot the push needs
    assign w_push_ok = r_push_valid & (~w_full | w_pop);
    assign w_ovf_ev  = r_push_valid & w_full & ~w_pop;
    assign w_clr     = (w_wr && w_addr == 2'd1 && pstrb[0]) ? pwdata[4:2] : 3'b000;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_push_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_enable <= 1'b1;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_ovf  <= (r_ovf  & ~w_clr[0]) | w_ovf_ev;
            r_perr <= (r_perr & ~w_clr[1]) | r_perr_ev;
            r_ferr <= (r_ferr & ~w_clr[2]) | r_ferr_ev;
            if (w_wr && w_addr == 2'd2 && pstrb[0]) begin
                r_enable <= pwdata[0];
                r_irq_en <= pwdata[1];
            end
            r_irq <= r_irq_en & (~w_empty | r_ovf | r_perr | r_ferr);
        end
    end

    assign irq = r_irq;

    // ---------------- read mux / error response ----------------
    logic [7:0]  w_count8;
    logic [31:0] w_status;
    assign w_count8 = 8'(r_count);
    assign w_status = {16'b0, w_count8, 3'b0, r_ferr, r_perr, r_ovf, w_full, w_empty};

    assign pslverr = w_access & ((w_addr == 2'd3) | ((w_addr == 2'd0) & pwrite));

    always_comb begin
        prdata = '0;
        if (w_rd) begin
            case (w_addr)
                2'd0:    prdata = w_empty ? 32'h0 : {23'b0, 1'b1, w_head};
                2'd1:    prdata = w_status;
                2'd2:    prdata = {30'b0, r_irq_en, r_enable};
                default: prdata = '0;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{paddr[31:4], paddr[1:0], pwdata[31:5], pstrb[3:1]};

endmodule

// File: doc/ps2_rx_apb.md
PS2_RX_APB -- requirements
Module: ps2_rx_apb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk/ps2_data (at least 2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000, idle clock cycles mid-frame before a frame is abandoned.
REQ-004 SHALL have port clock, input, 1, system clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port paddr, input, 32, APB address; only bits [3:2] decoded.
REQ-007 SHALL have ports psel, penable, pwrite, input, 1 each, APB controls.
REQ-008 SHALL have ports pwdata (input, 32) and pstrb (input, 4); only byte lane 0 is used.
REQ-009 SHALL have port pready, output, 1, tied 1 (zero wait states).
REQ-010 SHALL have port prdata, output, 32, read data.
REQ-011 SHALL have port pslverr, output, 1, error response.
REQ-012 SHALL have ports ps2_clk and ps2_data, input, 1 each, asynchronous PS/2 lines.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL define the access phase as psel=1 and penable=1; all register side effects occur only in that cycle, once per transfer.
REQ-015 SHALL decode the register map by paddr[3:2] as follows:
- 0 DATA (RO): [7:0] head byte, [8] valid.
- 1 STATUS: [0] empty, [1] full, [2] overflow, [3] parity_err, [4] frame_err, [15:8] count. Bits [4:2] are sticky and write-1-to-clear when pstrb[0]=1.
- 2 CTRL (RW): [0] enable (reset 1), [1] irq_en (reset 0).
- 3: unmapped.
REQ-016 SHALL drive pslverr=1 in the access phase for paddr[3:2]=3, or for a write to DATA; such accesses have no side effect and prdata=0.
REQ-017 SHALL return prdata=0 outside read access phases and in all unused bits.
REQ-018 SHALL pop exactly one entry on a DATA read access phase when the FIFO is non-empty; prdata shows the pre-pop head with valid=1.
REQ-019 SHALL return 0x000 on a DATA read when the FIFO is empty, with no pointer change.
REQ-020 SHALL detect a PS/2 falling edge as the last two synchroniser stages showing 1 then 0; one sample per edge.
REQ-021 SHALL receive frames of 11 bits, sampling ps2_data on each falling edge in the order start, data[0..7] (LSB first), parity, stop, using a 0..10 bit counter.
REQ-022 SHALL accept a frame only if start=0, stop=1 and the 9 bits data+parity have odd parity. The byte is pushed in the cycle after the stop-bit edge.
REQ-023 SHALL set parity_err on a parity failure and frame_err on a start/stop failure; the byte is discarded and the counter returns to 0.
REQ-024 SHALL count idle cycles since the last edge while the bit counter is nonzero; when the count reaches TIMEOUT_CYCLES, the counter returns to 0 and frame_err is set.
REQ-025 SHALL, when the FIFO is full and a pop happens in the same cycle as a push, accept the push; when full without a pop, drop the byte and set overflow.
REQ-026 SHALL wrap the pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH, with full = (count == FIFO_DEPTH).
REQ-027 SHALL, with enable=0, ignore line edges and hold the bit counter at 0; the FIFO stays readable. Clearing enable mid-frame discards the partial frame without setting error flags.
REQ-028 SHALL drive irq = irq_en AND (not empty OR overflow OR parity_err OR frame_err), registered (one cycle after the cause).
REQ-029 SHALL, when a W1C clear and a new error event coincide, leave the flag set.

Reset
REQ-030 SHALL, on reset=0 at a clock edge, clear pointers, count, bit counter, timeout counter and sticky flags, set enable=1 and irq_en=0, load the synchronisers with 1, and drive irq=0.
REQ-031 SHALL, on reset mid-frame, discard the partial frame; FIFO contents are lost.

Verification
REQ-032 SHALL pass this scenario: send valid frame 0x1C (parity bit 0), then read DATA -> prdata=0x11C; a second read -> 0x000; STATUS empty=1.
REQ-033 SHALL pass this scenario: send 0x1C with parity bit 1 -> FIFO empty, parity_err=1; write STATUS 0x08 -> parity_err=0.
REQ-034 SHALL pass this scenario: FIFO_DEPTH=4, send 5 frames 0x01..0x05 without reads -> count=4, full=1, overflow=1; reads return 0x101..0x104.
REQ-035 SHALL pass this scenario: send 4 bits, then hold lines high for TIMEOUT_CYCLES -> frame_err=1; the next valid frame 0x5A is received correctly.
REQ-036 SHALL pass this scenario: irq_en=1, receive one byte -> irq=1; read DATA -> irq=0 on the following cycle.
REQ-037 SHALL pass this scenario: read of paddr 0xC -> pslverr=1, prdata=0, no state change; assert reset=0 mid-frame -> all STATUS bits 0 except empty=1.
